// File: rtl/majority_pkg.sv
// Shared constants for the TMR majority vote point and its disagreement monitors.
package majority_pkg;

  localparam int unsigned CNT_W_DEF        = 8;
  localparam int unsigned FAULT_THRESH_DEF = 4;

  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_C = 2;

endpackage

// File: rtl/disagree_counter.sv
// Per-channel saturating disagreement counter with a sticky threshold fault flag.
module disagree_counter #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             fault_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] Thresh = CNT_W'(FAULT_THRESH);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             fault_d, fault_q;

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (clr_i) begin
      cnt_d   = '0;
      fault_d = 1'b0;
    end else begin
      if (inc_i && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Compare the next count so the flag rises on the edge the count reaches the threshold.
      if (cnt_d >= Thresh) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/majority_detector.sv
// Three-input TMR majority voter with a zero-latency vote, a registered copy and
// per-channel disagreement counting with sticky fault flags.
module majority_detector
  import majority_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned FAULT_THRESH = FAULT_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             clr,
  output logic             m,
  output logic             m_q,
  output logic             unanimous,
  output logic             dis_a,
  output logic             dis_b,
  output logic             dis_c,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic             fault_a,
  output logic             fault_b,
  output logic             fault_c,
  output logic             any_fault
);

  logic [2:0]       in_vec;
  logic [2:0]       dis_vec;
  logic [2:0]       fault_vec;
  logic [CNT_W-1:0] cnt_vec [3];

  assign in_vec[CH_A] = a;
  assign in_vec[CH_B] = b;
  assign in_vec[CH_C] = c;

  // The vote never consults fault state: no channel is ever masked.
  assign m         = (a & b) | (a & c) | (b & c);
  assign dis_vec   = in_vec ^ {3{m}};
  assign unanimous = (&in_vec) | ~(|in_vec);

  for (genvar i = 0; i < 3; i++) begin : g_ch
    disagree_counter #(
      .CNT_W        (CNT_W),
      .FAULT_THRESH (FAULT_THRESH)
    ) u_cnt (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clr_i   (clr),
      .inc_i   (dis_vec[i]),
      .cnt_o   (cnt_vec[i]),
      .fault_o (fault_vec[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 1'b0;
    end else begin
      m_q <= m;
    end
  end

  assign dis_a     = dis_vec[CH_A];
  assign dis_b     = dis_vec[CH_B];
  assign dis_c     = dis_vec[CH_C];
  assign cnt_a     = cnt_vec[CH_A];
  assign cnt_b     = cnt_vec[CH_B];
  assign cnt_c     = cnt_vec[CH_C];
  assign fault_a   = fault_vec[CH_A];
  assign fault_b   = fault_vec[CH_B];
  assign fault_c   = fault_vec[CH_C];
  assign any_fault = |fault_vec;

endmodule

// File: tb/tb_majority_detector.sv
// Bench for majority_detector: default instance (8-bit, threshold 4) and a small
// instance (2-bit, threshold 3) driven in parallel and checked against a counting model.
module tb_majority_detector;

  logic clk, rst_n, a, b, c, clr;

  logic       m0, mq0, un0, da0, db0, dc0, fa0, fb0, fc0, af0;
  logic [7:0] ca0, cb0, cc0;
  logic       m1, mq1, un1, da1, db1, dc1, fa1, fb1, fc1, af1;
  logic [1:0] ca1, cb1, cc1;

  int checks = 0;
  int errors = 0;

  majority_detector #(.CNT_W(8), .FAULT_THRESH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr(clr),
    .m(m0), .m_q(mq0), .unanimous(un0), .dis_a(da0), .dis_b(db0), .dis_c(dc0),
    .cnt_a(ca0), .cnt_b(cb0), .cnt_c(cc0),
    .fault_a(fa0), .fault_b(fb0), .fault_c(fc0), .any_fault(af0)
  );

  majority_detector #(.CNT_W(2), .FAULT_THRESH(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr(clr),
    .m(m1), .m_q(mq1), .unanimous(un1), .dis_a(da1), .dis_b(db1), .dis_c(dc1),
    .cnt_a(ca1), .cnt_b(cb1), .cnt_c(cc1),
    .fault_a(fa1), .fault_b(fb1), .fault_c(fc1), .any_fault(af1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance (0 = default, 1 = small), per channel (0 = a, 1 = b, 2 = c).
  int cmax[2] = '{255, 3};
  int cthr[2] = '{4, 3};
  int mcnt[2][3];
  bit mflt[2][3];
  bit mmq;

  function automatic bit vote(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmq = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 3; ch++) begin
          mcnt[d][ch] = 0;
          mflt[d][ch] = 1'b0;
        end
    end else begin
      logic [2:0] v;
      v   = {a, b, c};
      mmq = vote(v);
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 3; ch++) begin
          if (clr) begin
            mcnt[d][ch] = 0;
            mflt[d][ch] = 1'b0;
          end else begin
            if (v[2-ch] != vote(v) && mcnt[d][ch] < cmax[d]) mcnt[d][ch]++;
            if (mcnt[d][ch] >= cthr[d]) mflt[d][ch] = 1'b1;
          end
        end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    logic [2:0] v;
    v = {a, b, c};
    chk("m0", 32'(m0), 32'(vote(v)));
    chk("m1", 32'(m1), 32'(vote(v)));
    chk("unanimous", 32'(un0), 32'(v == 3'b000 || v == 3'b111));
    chk("dis0", 32'({da0, db0, dc0}), 32'(v ^ {3{vote(v)}}));
    chk("dis1", 32'({da1, db1, dc1}), 32'(v ^ {3{vote(v)}}));
    chk("m_q0", 32'(mq0), 32'(mmq));
    chk("m_q1", 32'(mq1), 32'(mmq));
    chk("cnt0", {8'd0, ca0, cb0, cc0}, 32'({mcnt[0][0][7:0], mcnt[0][1][7:0], mcnt[0][2][7:0]}));
    chk("cnt1", 32'({ca1, cb1, cc1}), 32'({mcnt[1][0][1:0], mcnt[1][1][1:0], mcnt[1][2][1:0]}));
    chk("fault0", 32'({fa0, fb0, fc0, af0}),
        32'({mflt[0][0], mflt[0][1], mflt[0][2], mflt[0][0] | mflt[0][1] | mflt[0][2]}));
    chk("fault1", 32'({fa1, fb1, fc1, af1}),
        32'({mflt[1][0], mflt[1][1], mflt[1][2], mflt[1][0] | mflt[1][1] | mflt[1][2]}));
  end

  task automatic set_in(input logic [2:0] v, input logic cl);
    {a, b, c} = v;
    clr       = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit exp_m[8];
    exp_m = '{0, 0, 0, 1, 0, 1, 1, 1};
    set_in(3'b000, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset m_q", 32'(mq0), 32'd0);
    chk("reset cnt", {8'd0, ca0, cb0, cc0}, 32'd0);
    chk("reset fault", 32'({fa0, fb0, fc0, af0, fa1, fb1, fc1, af1}), 32'd0);
    rst_n = 1'b1;

    // Exhaustive truth table, one vector per clock.
    for (int v = 0; v < 8; v++) begin
      set_in(3'(v), 1'b0);
      #1;
      chk("tt m", 32'(m0), 32'(exp_m[v]));
      chk("tt model", 32'(vote(3'(v))), 32'(exp_m[v]));
      chk("tt unanimous", 32'(un0), 32'(v == 0 || v == 7));
      tick();
    end

    // Registered output.
    set_in(3'b000, 1'b0);
    tick();
    chk("m_q low", 32'(mq0), 32'd0);
    set_in(3'b011, 1'b0);
    #1;
    chk("m_q before edge", 32'(mq0), 32'd0);
    tick();
    chk("m_q rise", 32'(mq0), 32'd1);
    set_in(3'b000, 1'b0);
    tick();
    chk("m_q fall", 32'(mq0), 32'd0);

    // Fault threshold on channel a (default instance).
    set_in(3'b000, 1'b1);
    tick();
    set_in(3'b011, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("thr cnt_a", 32'(ca0), 32'(k));
      chk("thr fault_a", 32'({fa0, af0}), (k == 4) ? 32'd3 : 32'd0);
      chk("thr cnt_b/c", 32'({cb0, cc0}), 32'd0);
    end

    // Saturation on channel b (small instance).
    set_in(3'b000, 1'b1);
    tick();
    set_in(3'b101, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat cnt_b", 32'(cb1), (k < 3) ? 32'(k) : 32'd3);
      chk("sat fault_b", 32'(fb1), 32'(k >= 3));
      chk("wide cnt_b", 32'(cb0), 32'(k));
    end

    // Clear has priority over an increment on channel c.
    set_in(3'b000, 1'b1);
    tick();
    set_in(3'b110, 1'b0);
    repeat (5) tick();
    chk("pre-clr cnt_c", 32'(cc0), 32'd5);
    chk("pre-clr fault_c", 32'(fc0), 32'd1);
    chk("pre-clr dis_c", 32'(dc0), 32'd1);
    set_in(3'b110, 1'b1);
    tick();
    chk("clr cnt_c", 32'(cc0), 32'd0);
    chk("clr fault_c", 32'(fc0), 32'd0);
    set_in(3'b110, 1'b0);
    tick();
    chk("resume cnt_c", 32'(cc0), 32'd1);

    // Asynchronous reset mid-cycle.
    tick();
    tick();
    chk("pre-rst cnt_c", 32'(cc0), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async cnt", 32'({ca0, cb0, cc0}), 32'd0);
    chk("async m_q", 32'(mq0), 32'd0);
    chk("async fault", 32'({fa1, fb1, fc1, af1}), 32'd0);
    chk("rst m high", 32'(m0), 32'd1);
    set_in(3'b001, 1'b0);
    #1;
    chk("rst m low", 32'(m0), 32'd0);
    tick();
    set_in(3'b110, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post-rst cnt_c", 32'(cc0), 32'd1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      set_in(3'($urandom_range(7)), $urandom_range(15) == 0);
      rst_n = ($urandom_range(60) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/majority_detector.md
# majority_detector

Three-input majority voter with registered output and per-channel disagreement monitoring, used as a TMR (triple-modular-redundancy) vote point. The voted output `m` is purely combinational, so downstream logic sees it with zero latency. A clocked monitor counts how often each input is outvoted and raises a sticky per-channel fault flag once that count reaches a threshold.

## Interface
Parameters:
- `CNT_W`, 8: width of each disagreement counter; must be ≥ 2.
- `FAULT_THRESH`, 4: count at which a channel fault is raised; range 1 to 2^CNT_W−1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `a`, `b`, `c` in 1 each: redundant input channels.
- `clr` in 1: synchronous clear of counters and fault flags.
- `m` out 1: combinational majority of a, b, c.
- `m_q` out 1: `m` registered once.
- `unanimous` out 1: combinational; high when a == b == c.
- `dis_a`, `dis_b`, `dis_c` out 1 each: combinational; high when that input differs from `m`.
- `cnt_a`, `cnt_b`, `cnt_c` out CNT_W each: disagreement counts.
- `fault_a`, `fault_b`, `fault_c` out 1 each: sticky channel fault flags.
- `any_fault` out 1: OR of the three fault flags.

## Operation
- Vote: m = (a&b) | (a&c) | (b&c). It is high when 2 or 3 inputs are 1.
- Disagreement: dis_x = x ^ m.
  - At most one dis_x is high at any time.
  - All three are low when `unanimous` is high.
- Counters, evaluated on each clock edge when not in reset:
  - If `clr` is high: all counters go to 0.
  - Otherwise, cnt_x increments by 1 when dis_x is high.
  - Counters saturate at 2^CNT_W−1 and never wrap.
- Fault flags, evaluated on each clock edge:
  - If `clr` is high: all flags go to 0.
  - Otherwise, fault_x is set when the next value of cnt_x is ≥ FAULT_THRESH, and holds once set.
- `clr` has priority over the increment in the same cycle.
- The vote output is independent of fault state; no channel is ever masked.
- Inputs are assumed synchronous to `clk` for the monitor. `m` remains valid for asynchronous inputs.

## Timing
- `m`, `unanimous`, `dis_*`: zero latency (combinational).
- `m_q`: one-cycle latency from `m`.
- `cnt_x`: reflects disagreement in cycle N at the output in cycle N+1.
- `fault_x`: rises on the same edge where cnt_x reaches FAULT_THRESH.
- Reset values, applied immediately on `rst_n` low:
  - m_q = 0, all cnt = 0, all fault = 0, any_fault = 0.
  - Combinational outputs continue to follow the inputs during reset.
- Reset asserted mid-count discards all counts. Counting resumes on the first edge after `rst_n` goes high.

## Structure
- Shared package `majority_pkg` holds:
  - default constants CNT_W_DEF = 8 and FAULT_THRESH_DEF = 4;
  - channel index constants CH_A = 0, CH_B = 1, CH_C = 2.
- Sub-module `disagree_counter` is instantiated three times. Each instance contains:
  - a saturating CNT_W counter with `clr`;
  - the sticky threshold flag.
- Vote, disagreement and unanimous logic live in the top level.

## Test plan
- Exhaustive truth table: step {a,b,c} through 000..111, one vector per 10 ns.
  - Required m: 0,0,0,1,0,1,1,1.
  - `unanimous` is high only for 000 and 111.
- Registered output: apply 011 for one cycle, then 000.
  - m_q is 1 exactly one cycle after m rises, then returns to 0.
- Fault threshold: with FAULT_THRESH=4, hold {a,b,c}=011 for 4 cycles.
  - cnt_a reads 1, 2, 3, 4; fault_a and any_fault rise with cnt_a = 4.
  - cnt_b and cnt_c stay 0.
- Saturation: with CNT_W=2, hold 101 for 6 cycles.
  - cnt_b stops at 3 and does not wrap.
  - fault_b is set once cnt_b reaches 3 (FAULT_THRESH=3).
- Clear priority: assert `clr` while dis_c is high, with cnt_c = 5.
  - Next cycle: cnt_c = 0 and fault_c = 0.
  - Counting resumes after `clr` drops.
- Asynchronous reset: drop `rst_n` mid-cycle while counts are nonzero.
  - Counts, flags and m_q clear immediately, without waiting for a clock edge.
  - m still tracks the inputs during reset.
